bridge_uart_scheduler: RTL
==========================

BRIDGE_UART_SCHEDULER -- requirements
Module: bridge_uart_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the read/write data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, meaning the address width.
REQ-003 SHALL have parameter RX_TIMEOUT, default 65535, meaning the maximum cycles to wait for a read reply.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rstn, input, 1; reset is synchronous and active-low.
REQ-006 SHALL have port req, input, 2, per-requester request level, held until its done pulse.
REQ-007 SHALL have port req_mode, input, 2, per-requester mode: 1 write, 0 read.
REQ-008 SHALL have port req_addr, input, 2*ADDR_WIDTH, with requester 0 in the low slice.
REQ-009 SHALL have port req_wdata, input, 2*DATA_WIDTH, with requester 0 in the low slice.
REQ-010 SHALL have port done, output, 2, a one-cycle completion pulse per requester.
REQ-011 SHALL have port err, output, 2, a timeout flag per requester, valid with done.
REQ-012 SHALL have port rdata, output, DATA_WIDTH, read data, valid with done.
REQ-013 SHALL have port u_din, output, DATA_WIDTH+ADDR_WIDTH+1, the UART TX frame {mode, wdata, addr}.
REQ-014 SHALL have port u_en, output, 1, a one-cycle UART transmit start.
REQ-015 SHALL have port u_tx_busy, input, 1, UART transmitter busy.
REQ-016 SHALL have port u_rx_ready, input, 1, UART received byte valid.
REQ-017 SHALL have port u_dout, input, DATA_WIDTH, UART received byte.

Function
REQ-018 SHALL implement the states IDLE, ISSUE, TX_START, TX_DRAIN, RX_WAIT and DONE.
REQ-019 SHALL, in IDLE with any req bit set, grant one requester round-robin, latch its mode, addr and wdata, and go to ISSUE.
REQ-020 SHALL arbitrate round-robin: on simultaneous requests, the requester not served last wins; after reset, requester 0 has priority.
REQ-021 SHALL, in ISSUE, drive u_din from the latched fields (wdata forced to 0 for reads), pulse u_en for exactly one cycle, and go to TX_START.
REQ-022 SHALL stay in TX_START until u_tx_busy=1, then go to TX_DRAIN.
REQ-023 SHALL stay in TX_DRAIN until u_tx_busy=0, then go to DONE for a write or RX_WAIT for a read.
REQ-024 SHALL, in RX_WAIT, capture u_dout into rdata on u_rx_ready=1 and go to DONE.
REQ-025 SHALL, in RX_WAIT, count cycles and, when the count reaches RX_TIMEOUT without u_rx_ready, set err for the granted requester, set rdata=0, and go to DONE.
REQ-026 SHALL, in DONE, pulse done[granted] for one cycle, update the round-robin pointer, and return to IDLE.
REQ-027 SHALL accept no new grant until the state machine is back in IDLE, so a request arriving mid-transaction waits at least until the cycle after DONE.
REQ-028 SHALL ignore u_rx_ready in every state other than RX_WAIT (stray bytes dropped).
REQ-029 SHALL sample requester fields only at grant, so changes to req_* after grant have no effect.
REQ-030 SHALL give a transaction latency of at least 4 cycles for a write (grant to done), with the exact figure set by the u_tx_busy timing.
REQ-031 SHALL not let the timeout counter wrap; it saturates at RX_TIMEOUT and clears on entry to RX_WAIT.

Reset
REQ-032 SHALL, with rstn=0 at a clk edge, force state IDLE, done=0, err=0, rdata=0, u_din=0, u_en=0, counter=0 and the round-robin pointer to requester 0.
REQ-033 SHALL, on reset mid-transaction, abandon the transaction without asserting done; requesters must re-request.

Structure
REQ-034 SHALL place the state encodings and the frame field offsets (ADDR at [ADDR_WIDTH-1:0], WDATA next, MODE at the MSB) in the shared bridge package, for reuse by bus_bridge_master frame decode.
REQ-035 SHALL contain one natural sub-module, rr_arbiter2 (two-way round-robin grant with pointer update on an advance strobe).

Verification
REQ-036 SHALL cover: req=01, write, addr=0x0A5, wdata=0x3C -> one u_en pulse with u_din=0x13C0A5, then done=01 after tx_busy falls, and err=0.
REQ-037 SHALL cover: req=10, read, addr=0x123, with u_rx_ready pulsed and u_dout=0x7E in RX_WAIT -> done=10, rdata=0x7E, err=0.
REQ-038 SHALL cover: req=11 held for four transactions -> grants in the order 0,1,0,1, each done a single pulse.
REQ-039 SHALL cover: a read with no reply and RX_TIMEOUT=16 -> done and err for that requester 16 cycles after RX_WAIT entry, with rdata=0.
REQ-040 SHALL cover: rstn=0 during TX_DRAIN -> all outputs 0 the next cycle, state IDLE, and no done pulse.
REQ-041 SHALL cover: a u_rx_ready pulse while IDLE -> no done, and rdata unchanged.

Source files
------------

// File: rtl/bridge_uart_scheduler_pkg.sv
// Shared state encodings and UART frame layout for the bridge scheduler
// and the bus_bridge_master frame decode.
package bridge_uart_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_TX_START,
    S_TX_DRAIN,
    S_RX_WAIT,
    S_DONE
  } state_t;

  localparam logic MODE_WR = 1'b1;
  localparam logic MODE_RD = 1'b0;

  localparam int FRM_ADDR_LSB = 0;

  function automatic int frm_wdata_lsb(input int aw);
    return aw;
  endfunction

  function automatic int frm_mode_bit(input int dw, input int aw);
    return dw + aw;
  endfunction

  function automatic int frm_width(input int dw, input int aw);
    return dw + aw + 1;
  endfunction

  function automatic logic [1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/bridge_uart_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer names the favoured requester
// and moves past the served one on each advance strobe.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       served,
  output logic       gnt_idx,
  output logic       gnt_vld
);

  logic ptr;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~served;
    end
  end

  always_comb begin
    gnt_vld = |req;
    gnt_idx = 1'b0;
    unique case (req)
      2'b11:   gnt_idx = ptr;
      2'b10:   gnt_idx = 1'b1;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/bridge_uart_scheduler.sv
// Schedules two requesters onto one UART link: frame out, wait for the
// transmitter to drain, then (for reads) wait for a reply byte.
module bridge_uart_scheduler
  import bridge_uart_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int RX_TIMEOUT = 65535
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [1:0]                       req,
  input  logic [1:0]                       req_mode,
  input  logic [2*ADDR_WIDTH-1:0]          req_addr,
  input  logic [2*DATA_WIDTH-1:0]          req_wdata,
  output logic [1:0]                       done,
  output logic [1:0]                       err,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [DATA_WIDTH+ADDR_WIDTH:0]   u_din,
  output logic                             u_en,
  input  logic                             u_tx_busy,
  input  logic                             u_rx_ready,
  input  logic [DATA_WIDTH-1:0]            u_dout
);

  localparam int FW       = frm_width(DATA_WIDTH, ADDR_WIDTH);
  localparam int WD_LSB   = frm_wdata_lsb(ADDR_WIDTH);
  localparam int MODE_BIT = frm_mode_bit(DATA_WIDTH, ADDR_WIDTH);
  localparam int CW       = $clog2(RX_TIMEOUT + 1);

  localparam logic [CW-1:0] TO_LAST = CW'(RX_TIMEOUT - 1);
  localparam logic [CW-1:0] TO_MAX  = CW'(RX_TIMEOUT);

  state_t                  state;
  logic                    gidx;
  logic [CW-1:0]           cnt;

  logic                    gnt_idx;
  logic                    gnt_vld;
  logic                    g_mode;
  logic [ADDR_WIDTH-1:0]   g_addr;
  logic [DATA_WIDTH-1:0]   g_wdata;
  logic [FW-1:0]           frame;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (req),
    .advance (state == S_DONE),
    .served  (gidx),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    g_mode  = req_mode[gnt_idx];
    g_addr  = gnt_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                      : req_addr[ADDR_WIDTH-1:0];
    g_wdata = gnt_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                      : req_wdata[DATA_WIDTH-1:0];
    frame   = '0;
    frame[FRM_ADDR_LSB +: ADDR_WIDTH] = g_addr;
    frame[WD_LSB +: DATA_WIDTH] =
      (g_mode == MODE_WR) ? g_wdata : '0;
    frame[MODE_BIT] = g_mode;
  end

  // u_din doubles as the latched request: it is loaded once at grant
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
      gidx  <= 1'b0;
      cnt   <= '0;
      done  <= '0;
      err   <= '0;
      rdata <= '0;
      u_din <= '0;
      u_en  <= 1'b0;
    end else begin
      u_en <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (gnt_vld) begin
            gidx  <= gnt_idx;
            u_din <= frame;
            u_en  <= 1'b1;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_TX_START;
        end
        S_TX_START: begin
          if (u_tx_busy) state <= S_TX_DRAIN;
        end
        S_TX_DRAIN: begin
          if (!u_tx_busy) begin
            cnt <= '0;
            if (u_din[MODE_BIT] == MODE_WR) begin
              done  <= req_onehot(gidx);
              state <= S_DONE;
            end else begin
              state <= S_RX_WAIT;
            end
          end
        end
        S_RX_WAIT: begin
          if (u_rx_ready) begin
            rdata <= u_dout;
            done  <= req_onehot(gidx);
            state <= S_DONE;
          end else if (cnt == TO_LAST) begin
            rdata <= '0;
            err   <= req_onehot(gidx);
            done  <= req_onehot(gidx);
            state <= S_DONE;
          end else if (cnt != TO_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          done  <= '0;
          err   <= '0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
